// File: rtl/pipe_merge_arbiter.sv
// Purpose: merges pipeline 1/2 result streams onto one sink port; drives global_stall for producer and pipelines.
// Latency: an item accepted at edge N appears on sink_* after edge N (one register stage, no buffering).
// Backpressure: global_stall asserts on a dual-pipe conflict or a busy sink; the losing item is held upstream.
module pipe_merge_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_valid,
    input  logic              p1_flush,
    input  logic [DATA_W-1:0] p2_data,
    input  logic              p2_valid,
    input  logic              p2_flush,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic [DATA_W-1:0] sink_data,
    output logic              sink_flush,
    output logic              sink_src,
    output logic              global_stall,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {
        ARB    = 1'b0,
        SECOND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic               rr_pri_q, rr_pri_d;
    logic               sink_valid_q, sink_valid_d;
    logic [DATA_W-1:0]  sink_data_q, sink_data_d;
    logic               sink_flush_q, sink_flush_d;
    logic               sink_src_q, sink_src_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

    logic               cand1;
    logic               cand2;
    logic               slot_free;
    logic               load_en;
    logic               load_sel;
    logic               stall;
    logic               conflict;

    // Arbitration: pick which pipeline (if any) loads the sink slot and whether the world must freeze.
    always_comb begin
        state_d        = state_q;
        rr_pri_d       = rr_pri_q;
        sink_valid_d   = sink_valid_q;
        sink_data_d    = sink_data_q;
        sink_flush_d   = sink_flush_q;
        sink_src_d     = sink_src_q;
        stall_cycles_d = stall_cycles_q;
        conflict_cnt_d = conflict_cnt_q;
        load_en        = 1'b0;
        load_sel       = 1'b0;
        stall          = 1'b0;
        conflict       = 1'b0;

        // A flush marker is an item in its own right, even without valid.
        cand1     = p1_valid | p1_flush;
        cand2     = p2_valid | p2_flush;
        slot_free = ~sink_valid_q | sink_ready;

        case (state_q)
            ARB: begin
                if (cand1 && cand2) begin
                    stall = 1'b1;
                    if (slot_free) begin
                        load_en  = 1'b1;
                        load_sel = rr_pri_q;
                        conflict = 1'b1;
                        state_d  = SECOND;
                    end
                end else if (cand1 || cand2) begin
                    if (slot_free) begin
                        load_en  = 1'b1;
                        load_sel = cand2;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            SECOND: begin
                // The winner's inputs are still frozen on its port; only the loser matters here.
                if (slot_free) begin
                    load_en  = 1'b1;
                    load_sel = ~rr_pri_q;
                    rr_pri_d = ~rr_pri_q;
                    state_d  = ARB;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        if (load_en) begin
            sink_valid_d = 1'b1;
            sink_data_d  = load_sel ? p2_data  : p1_data;
            sink_flush_d = load_sel ? p2_flush : p1_flush;
            sink_src_d   = load_sel;
        end else if (sink_valid_q && sink_ready) begin
            sink_valid_d = 1'b0;
        end

        if (stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
        if (conflict && (conflict_cnt_q != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_ONE;
        end
    end

    // State, sink register and statistics; reset drops any loser pending in SECOND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ARB;
            rr_pri_q       <= 1'b0;
            sink_valid_q   <= 1'b0;
            sink_data_q    <= '0;
            sink_flush_q   <= 1'b0;
            sink_src_q     <= 1'b0;
            stall_cycles_q <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_pri_q       <= rr_pri_d;
            sink_valid_q   <= sink_valid_d;
            sink_data_q    <= sink_data_d;
            sink_flush_q   <= sink_flush_d;
            sink_src_q     <= sink_src_d;
            stall_cycles_q <= stall_cycles_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign sink_valid   = sink_valid_q;
    assign sink_data    = sink_data_q;
    assign sink_flush   = sink_flush_q;
    assign sink_src     = sink_src_q;
    assign stall_cycles = stall_cycles_q;
    assign conflict_cnt = conflict_cnt_q;
    // Stall must never freeze the pipelines while the block itself is held in reset.
    assign global_stall = stall & ~reset;

endmodule
